// File: rtl/spi_master_mode.sv
// SPI master: run-time CPOL/CPHA, programmable SCL half-period, N chip selects,
// optional 3-wire half-duplex on the shared sdo_sdio pin. One DATA_W word per start.
module spi_master_mode #(
  parameter  int CS_INST = 1,
  parameter  int DATA_W  = 8,
  parameter  int DIV_W   = 8,
  localparam int CSW     = (CS_INST > 1) ? $clog2(CS_INST) : 1,
  localparam int LW      = $clog2(DATA_W + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cpol,
  input  logic               cpha,
  input  logic               three_wire,
  input  logic [LW-1:0]      tx_len,
  input  logic [CSW-1:0]     cs_sel,
  input  logic [DIV_W-1:0]   clk_div,
  input  logic [DATA_W-1:0]  tx_data,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  rx_data,
  output logic               scl,
  output logic [CS_INST-1:0] cs_n,
  input  logic               sdi,
  inout  wire                sdo_sdio
);
  localparam int EW = $clog2(2 * DATA_W + 1);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_e;
  state_e state_q, state_d;

  logic [DIV_W-1:0]   hcnt_q, div_q;
  logic [EW-1:0]      ecnt_q;
  logic [LW-1:0]      bit_q, tlen_q, bit_nx;
  logic [DATA_W-1:0]  tx_q, rx_q, rx_data_q;
  logic [CS_INST-1:0] cs_n_q, cs_dec;
  logic               cpol_q, cpha_q, tw_q, scl_q, oe_q, done_q;
  logic               hend, tog, lead, smp, adv, rx_bit;

  assign hend   = (hcnt_q == div_q);
  // Edge 0 fires at the end of LEAD; XFER's last half-period has no edge.
  assign tog    = hend && ((state_q == LEAD) ||
                  ((state_q == XFER) && (ecnt_q != EW'(2 * DATA_W))));
  assign lead   = ~ecnt_q[0];
  assign smp    = tog && (cpha_q ? !lead : lead);
  assign adv    = tog && (cpha_q ? (lead && (ecnt_q != '0))
                                 : (!lead && (ecnt_q != EW'(2 * DATA_W - 1))));
  assign bit_nx = bit_q + LW'(1);
  // Bits the master drives itself are taken from its own output, not the pad.
  assign rx_bit = tw_q ? (oe_q ? tx_q[DATA_W-1] : sdo_sdio) : sdi;

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < CS_INST; i++)
      if (cs_sel == CSW'(i)) cs_dec[i] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LEAD;
      LEAD:    if (hend) state_d = XFER;
      XFER:    if (hend && (ecnt_q == EW'(2 * DATA_W))) state_d = TRAIL;
      TRAIL:   if (hend) state_d = GAP;
      GAP:     if (hend) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      div_q     <= '0;
      ecnt_q    <= '0;
      bit_q     <= '0;
      tlen_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      cs_n_q    <= '1;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tw_q      <= 1'b0;
      scl_q     <= 1'b0;
      oe_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (state_q == IDLE) begin
        hcnt_q <= '0;
        if (start) begin
          cpol_q <= cpol;
          cpha_q <= cpha;
          tw_q   <= three_wire;
          tlen_q <= tx_len;
          div_q  <= clk_div;
          tx_q   <= tx_data;
          rx_q   <= '0;
          scl_q  <= cpol;
          cs_n_q <= cs_dec;
          ecnt_q <= '0;
          bit_q  <= '0;
          oe_q   <= !three_wire || (tx_len != '0);
        end
      end else begin
        hcnt_q <= hend ? '0 : hcnt_q + DIV_W'(1);
      end
      if (tog) begin
        scl_q  <= ~scl_q;
        ecnt_q <= ecnt_q + EW'(1);
      end
      if (smp) rx_q <= {rx_q[DATA_W-2:0], rx_bit};
      if (adv) begin
        tx_q  <= {tx_q[DATA_W-2:0], 1'b0};
        bit_q <= bit_nx;
        oe_q  <= !tw_q || (bit_nx < tlen_q);
      end
      if ((state_q == TRAIL) && hend) cs_n_q <= '1;
      if ((state_q == GAP) && hend) begin
        done_q    <= 1'b1;
        rx_data_q <= rx_q;
        tx_q      <= '0;
        oe_q      <= !tw_q;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign scl      = scl_q;
  assign cs_n     = cs_n_q;
  assign sdo_sdio = oe_q ? tx_q[DATA_W-1] : 1'bz;

endmodule

// File: tb/tb_spi_master_mode.sv
// Directed bench for spi_master_mode: 5 selects (so index 5 is out of range), 8-bit words,
// with a small SPI slave model that follows the selected CPHA and 3-wire turnaround.
module tb_spi_master_mode;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, three_wire = 1'b0;
  logic [3:0] tx_len = '0;
  logic [2:0] cs_sel = '0;
  logic [7:0] clk_div = '0, tx_data = '0;
  logic       busy, done, scl, sdi;
  logic [7:0] rx_data;
  logic [4:0] cs_n;
  wire        sdio;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  spi_master_mode #(.CS_INST(5), .DATA_W(8), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cpol(cpol), .cpha(cpha),
    .three_wire(three_wire), .tx_len(tx_len), .cs_sel(cs_sel), .clk_div(clk_div),
    .tx_data(tx_data), .busy(busy), .done(done), .rx_data(rx_data), .scl(scl),
    .cs_n(cs_n), .sdi(sdi), .sdo_sdio(sdio)
  );

  // Slave model: counts SCL edges of the current transfer, presents its word MSB first.
  logic       loop_en = 1'b0, tw_mode = 1'b0, s_cpha = 1'b0;
  logic [3:0] s_tlen = '0;
  logic [7:0] s_tx = '0, s_rx = '0;
  int         s_ecnt = 0;
  logic       scl_d = 1'b0, busy_d = 1'b0;
  logic       s_bit, s_oe;

  always_comb begin
    int p;
    p = s_cpha ? ((s_ecnt == 0) ? 0 : (s_ecnt - 1) / 2) : s_ecnt / 2;
    if (p > 7) p = 7;
    s_bit = s_tx[7-p];
    s_oe  = tw_mode && busy && (p >= int'(s_tlen));
  end

  assign sdio = s_oe ? s_bit : 1'bz;
  assign sdi  = loop_en ? sdio : s_bit;

  always @(negedge clk) begin
    if (busy && busy_d && (scl != scl_d)) begin
      s_ecnt <= s_ecnt + 1;
      if ((((s_ecnt + 1) % 2) == 1) != s_cpha) s_rx <= {s_rx[6:0], sdio};
    end
    if (!busy) s_ecnt <= 0;
    scl_d  <= scl;
    busy_d <= busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One transfer; n counts clk edges after the accepting edge.
  task automatic xfer(input logic pol, input logic pha, input logic tw, input logic [3:0] tl,
                      input logic [2:0] sel, input logic [7:0] div, input logic [7:0] tx,
                      output int lat, output int first, output int rises,
                      output logic [4:0] cs1, output logic b1);
    logic ps;
    @(negedge clk);
    cpol = pol; cpha = pha; three_wire = tw; tx_len = tl;
    cs_sel = sel; clk_div = div; tx_data = tx; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1; first = -1; rises = 0; ps = pol; cs1 = '0; b1 = 1'b0;
    for (int n = 1; n < 4000 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin cs1 = cs_n; b1 = busy; end
      if (first < 0 && scl != pol) first = n;
      if (!ps && scl) rises++;
      ps = scl;
      if (done) lat = n;
    end
    chk("done_seen", 32'(lat >= 0), 32'd1);
  endtask

  int lat, first, rises, dn, rs, bd, nb;
  logic [4:0] cs1;
  logic b1;

  initial begin
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs_n", cs_n, 5'b11111);
    chk("rst_scl", scl, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_sdo", sdio, 0);
    @(negedge clk) rst_n = 1'b1;

    // Mode 0, h=2, loopback
    loop_en = 1'b1; s_cpha = 1'b0;
    xfer(0, 0, 0, 0, 0, 8'd1, 8'hA5, lat, first, rises, cs1, b1);
    chk("m0_rx", rx_data, 8'hA5);
    chk("m0_lat", lat, 38);
    chk("m0_first", first, 2);
    chk("m0_rises", rises, 8);
    chk("m0_slv_rx", s_rx, 8'hA5);
    chk("m0_busy1", b1, 1);
    chk("m0_cs", cs1, 5'b11110);
    chk("m0_done_busy", busy, 0);

    // Mode 3, h=3, slave returns C3
    loop_en = 1'b0; s_cpha = 1'b1; s_tx = 8'hC3;
    xfer(1, 1, 0, 0, 1, 8'd2, 8'h3C, lat, first, rises, cs1, b1);
    chk("m3_rx", rx_data, 8'hC3);
    chk("m3_slv_rx", s_rx, 8'h3C);
    chk("m3_first", first, 3);
    chk("m3_lat", lat, 57);
    chk("m3_idle_scl", scl, 1);
    chk("m3_cs", cs1, 5'b11101);

    // Chip select 2, then out-of-range 5
    s_cpha = 1'b0; s_tx = 8'h5A;
    xfer(0, 0, 0, 0, 2, 8'd0, 8'h11, lat, first, rises, cs1, b1);
    chk("cs2_cs", cs1, 5'b11011);
    chk("cs2_rx", rx_data, 8'h5A);
    xfer(0, 0, 0, 0, 5, 8'd0, 8'h22, lat, first, rises, cs1, b1);
    chk("cs5_cs", cs1, 5'b11111);
    chk("cs5_lat", lat, 19);
    chk("cs5_rx", rx_data, 8'h5A);

    // 3-wire: 3 bits written then slave drives 10110
    tw_mode = 1'b1; s_tlen = 4'd3; s_tx = 8'b0001_0110;
    xfer(0, 0, 1, 4'd3, 0, 8'd1, 8'b1010_1001, lat, first, rises, cs1, b1);
    chk("3w_rx", rx_data, 8'hB6);
    s_tlen = 4'd0; s_tx = 8'h5A;
    xfer(0, 0, 1, 4'd0, 0, 8'd0, 8'hFF, lat, first, rises, cs1, b1);
    chk("3w_read", rx_data, 8'h5A);
    s_tlen = 4'd8; s_tx = 8'h00;
    xfer(0, 0, 1, 4'd8, 0, 8'd0, 8'h96, lat, first, rises, cs1, b1);
    chk("3w_write", rx_data, 8'h96);
    chk("3w_slv_rx", s_rx, 8'h96);
    tw_mode = 1'b0;

    // start held high: one transfer per accept, 1 idle cycle between
    @(negedge clk);
    cpol = 0; cpha = 0; three_wire = 0; clk_div = 0; cs_sel = 0; tx_data = 8'h0F; start = 1'b1;
    dn = 0; rs = 0; bd = 0; b1 = 1'b0;
    for (int n = 0; n < 62; n++) begin
      @(posedge clk); #1;
      if (done) begin dn++; if (busy) bd++; end
      if (busy && !b1) rs++;
      b1 = busy;
    end
    start = 1'b0;
    chk("hold_dones", dn, 3);
    chk("hold_accepts", rs, 4);
    chk("hold_busy_on_done", bd, 0);
    lat = -1;
    for (int n = 0; n < 100 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (done) lat = n;
    end
    chk("hold_last_done", 32'(lat >= 0), 32'd1);
    nb = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (busy) nb++;
    end
    chk("hold_no_queue", nb, 0);

    // Reset at the 4th SCL edge, mode 2 so idle-high SCL must drop to 0
    @(negedge clk);
    cpol = 1; cpha = 0; clk_div = 8'd1; cs_sel = 3; tx_data = 8'hE7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    rises = 0; b1 = scl;
    for (int n = 1; n < 200 && rises < 4; n++) begin
      @(posedge clk); #1;
      if (scl != b1) rises++;
      b1 = scl;
    end
    chk("rst_edges", rises, 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", cs_n, 5'b11111);
    chk("mid_rst_scl", scl, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rx", rx_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("mid_rst_no_done", dn, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
